// File: rtl/sine_playback_ctrl.sv
// rtl/sine_playback_ctrl.sv - sine table playback sequencer with rate divider, stride and valid/ready output
module sine_playback_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] step,
    input  logic [DIV_W-1:0]  rate_div,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, HOLD, WAIT_TICK} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, step_q, step_d, mem_addr_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d, div_q, div_d;
    logic                loop_q, loop_d;
    logic                mem_rd_d, sample_valid_d, done_d;
    logic [DATA_W-1:0]   sample_d;
    logic [ADDR_W:0]     sum;

    // Extra top bit flags running off the end of the table.
    assign sum = {1'b0, addr_q} + {1'b0, step_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            step_q       <= '0;
            cnt_q        <= '0;
            div_q        <= '0;
            loop_q       <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            loop_q       <= loop_d;
            mem_addr     <= mem_addr_d;
            mem_rd       <= mem_rd_d;
            sample       <= sample_d;
            sample_valid <= sample_valid_d;
            busy         <= (state_d != IDLE);
            done         <= done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        step_d         = step_q;
        cnt_d          = cnt_q;
        div_d          = div_q;
        loop_d         = loop_q;
        mem_addr_d     = mem_addr;
        mem_rd_d       = 1'b0;
        sample_d       = sample;
        sample_valid_d = sample_valid;
        done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    loop_d     = loop_en;
                    div_d      = rate_div;
                    step_d     = (step == '0) ? ADDR_W'(1) : step;
                    addr_d     = '0;
                    mem_addr_d = '0;
                    mem_rd_d   = 1'b1;
                    state_d    = READ;
                end
            end
            READ: state_d = CAPTURE;
            CAPTURE: begin
                sample_d       = mem_data;
                sample_valid_d = 1'b1;
                state_d        = HOLD;
            end
            HOLD: begin
                if (sample_valid && sample_ready) begin
                    sample_valid_d = 1'b0;
                    if (sum[ADDR_W] && !loop_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = sum[ADDR_W-1:0];
                        cnt_d   = '0;
                        state_d = WAIT_TICK;
                    end
                end
            end
            WAIT_TICK: begin
                if (cnt_q == div_q) begin
                    mem_addr_d = addr_q;
                    mem_rd_d   = 1'b1;
                    state_d    = READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything except an idle controller.
        if (stop && state_q != IDLE) begin
            state_d        = IDLE;
            sample_valid_d = 1'b0;
            mem_rd_d       = 1'b0;
            done_d         = 1'b0;
        end
    end

endmodule

// File: doc/sine_playback_ctrl.md
Name: sine_playback_ctrl

Overview:
Playback sequencer for the 256-entry signed sine-wave sample memory (SineWave.mem image, 8-bit samples). It generates read addresses and read strobes at a programmable sample rate with a programmable address stride, so one table produces several tones. Each fetched sample goes to a downstream consumer (display/audio path) over a valid/ready handshake. It supports one-shot and looping playback with start/stop control.

Parameters:
ADDR_W, 8, memory address width (table depth 2^ADDR_W)
DATA_W, 8, sample width (signed, two's complement)
DIV_W, 16, width of the sample-rate divider

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins playback when idle
stop  in  1  single-cycle pulse; aborts playback
loop_en  in  1  1 = wrap and continue, 0 = one-shot; latched at start
step  in  ADDR_W  address increment per sample; latched at start
rate_div  in  DIV_W  extra idle cycles between samples; latched at start
mem_addr  out  ADDR_W  registered read address to sample memory
mem_rd  out  1  read strobe; memory returns data one cycle later
mem_data  in  DATA_W  signed sample from memory
sample  out  DATA_W  signed sample to consumer
sample_valid  out  1  sample is valid
sample_ready  in  1  consumer accepts sample
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse at one-shot completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE. mem_addr, mem_rd, sample, sample_valid, done, internal address, divider counter and latched config are all 0.
- States: IDLE, READ, CAPTURE, HOLD, WAIT_TICK. busy = (state != IDLE). All outputs are registered.
- IDLE: on start=1 and stop=0, latch loop_en, rate_div and step (step=0 is latched as 1), set addr=0, go to READ. No wait tick precedes the first sample. If start and stop are both high, remain in IDLE.
- READ (1 cycle): mem_rd=1 and mem_addr=addr. Next state is CAPTURE.
- CAPTURE (1 cycle): mem_data is valid. Register sample<=mem_data, set sample_valid<=1, go to HOLD.
- HOLD: sample and sample_valid stay stable until sample_valid and sample_ready are both high. On that handshake:
  - Clear sample_valid the next cycle.
  - Form a 9-bit sum = addr + step.
  - If sum[8]=1 and loop_en=0: pulse done for 1 cycle and go to IDLE.
  - Otherwise: addr<=sum[7:0] (modulo-256 wrap), clear the counter, go to WAIT_TICK.
- WAIT_TICK: the counter increments each cycle. When counter==rate_div, go to READ. WAIT_TICK lasts rate_div+1 cycles.
- Sample period with sample_ready held high is rate_div+4 cycles, measured mem_rd-to-mem_rd.
- stop=1 in any non-IDLE state: go to IDLE next cycle, clear sample_valid and mem_rd, no done pulse. stop in IDLE is ignored.
- start while busy is ignored. Latched configuration cannot change mid-playback.
- Backpressure: no new mem_rd is issued while a sample is pending in HOLD. Samples are never dropped or duplicated.
- Address wrap: in loop mode the sequence continues modulo 256 indefinitely. With step=1 it repeats 0..255.
- done and sample_valid never assert in the same cycle. done is asserted only on one-shot completion, never on stop or reset.
- Reset mid-operation: immediate return to the reset values above. The first start after reset behaves like a fresh start.

Test Plan:
1. One-shot, step=1, rate_div=0, sample_ready=1: exactly 256 mem_rd pulses at addresses 0..255, spaced 4 cycles apart. Each sample equals SineWave.mem[addr]. done pulses once, the cycle after the 256th handshake. busy falls with done.
2. One-shot, step=3, rate_div=9: addresses 0,3,...,255 give 86 samples. mem_rd pulses are 13 cycles apart. done follows sample 86 (258 overflows).
3. Loop, step=64: address sequence 0,64,128,192,0,64,... persists past 10 samples with no done. A stop pulse gives busy=0 and sample_valid=0 next cycle, with no done.
4. Backpressure: sample_ready=0 for 10 cycles while in HOLD. sample_valid stays 1, sample stays constant, mem_rd stays 0. Releasing ready resumes the sequence with no skipped addresses.
5. Edge controls:
   - step=0 behaves as step=1.
   - start while busy does not restart (address sequence continues).
   - start and stop in the same cycle in IDLE leaves busy=0.
6. Async reset: drive rst_n=0 mid-HOLD, between clock edges. All outputs read 0 before the next clk edge. After release, a new start plays from address 0.
